// File: rtl/screen_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : screen_plotter
//  Description : Full-screen raster plotter that walks every pixel of a frame,
//                reads the colour from a synchronous image ROM and drives the
//                VGA adapter write port.
//  Revision    : 1.0 - initial release
// ============================================================================
module screen_plotter #(
    parameter int WIDTH       = 160,
    parameter int HEIGHT      = 120,
    parameter int X_BITS      = 8,
    parameter int Y_BITS      = 7,
    parameter int ADDR_BITS   = 15,
    parameter int COLOUR_BITS = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic [1:0]             screen_sel,
    output logic                   busy,
    output logic                   plot_done,
    output logic [1:0]             rom_scr,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [COLOUR_BITS-1:0] rom_data,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_DRAW  = 2'd1;
    localparam logic [1:0] c_FLUSH = 2'd2;

    localparam logic [X_BITS-1:0] c_X_LAST = X_BITS'(WIDTH - 1);
    localparam logic [Y_BITS-1:0] c_Y_LAST = Y_BITS'(HEIGHT - 1);

    logic [1:0]        r_state;
    logic [X_BITS-1:0] r_cnt_x;
    logic [Y_BITS-1:0] r_cnt_y;

    logic w_x_last;
    logic w_y_last;

    assign w_x_last = (r_cnt_x == c_X_LAST);
    assign w_y_last = (r_cnt_y == c_Y_LAST);

    assign busy   = (r_state != c_IDLE);
    assign colour = rom_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt_x   <= '0;
            r_cnt_y   <= '0;
            rom_addr  <= '0;
            rom_scr   <= '0;
            x         <= '0;
            y         <= '0;
            plot      <= 1'b0;
            plot_done <= 1'b0;
        end else begin
            plot      <= 1'b0;
            plot_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (go) begin
                        rom_scr  <= screen_sel;
                        r_cnt_x  <= '0;
                        r_cnt_y  <= '0;
                        rom_addr <= '0;
                        r_state  <= c_DRAW;
                    end
                end
                c_DRAW: begin
                    // ROM data for this address arrives next cycle, so the
                    // coordinates are delayed by one register to line up.
                    x    <= r_cnt_x;
                    y    <= r_cnt_y;
                    plot <= 1'b1;
                    if (w_x_last) begin
                        r_cnt_x <= '0;
                        if (w_y_last) begin
                            r_state <= c_FLUSH;
                        end else begin
                            r_cnt_y <= r_cnt_y + Y_BITS'(1);
                        end
                    end else begin
                        r_cnt_x <= r_cnt_x + X_BITS'(1);
                    end
                    // Hold on the final pixel so the index never exceeds N-1.
                    if (!(w_x_last && w_y_last)) begin
                        rom_addr <= rom_addr + ADDR_BITS'(1);
                    end
                end
                c_FLUSH: begin
                    plot_done <= 1'b1;
                    r_state   <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_screen_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_screen_plotter
//  Description : Self-checking bench for screen_plotter on a 4x3 frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_screen_plotter;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic [1:0] screen_sel = 2'd0;
    logic       busy, plot_done, plot;
    logic [1:0] rom_scr;
    logic [3:0] rom_addr;
    logic [2:0] rom_data = 3'd0;
    logic [1:0] x;
    logic [1:0] y;
    logic [2:0] colour;

    screen_plotter #(
        .WIDTH(W), .HEIGHT(H), .X_BITS(2), .Y_BITS(2),
        .ADDR_BITS(4), .COLOUR_BITS(3)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .screen_sel(screen_sel),
        .busy(busy), .plot_done(plot_done), .rom_scr(rom_scr),
        .rom_addr(rom_addr), .rom_data(rom_data), .x(x), .y(y),
        .colour(colour), .plot(plot)
    );

    always #5 clk = ~clk;

    // Synchronous image ROM: colour is the low bits of the pixel index.
    always @(posedge clk) rom_data <= rom_addr[2:0];

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: m_k counts edges since the go-sampling edge
    // (-1 = idle, 0 = frame accepted, 1..N = pixel k-1 written, N+1 = done).
    int m_k   = -1;
    int m_scr = 0;
    int m_x   = 0;
    int m_y   = 0;

    typedef struct {
        bit       rst;
        bit       go;
        bit [1:0] sel;
        bit       e_plot;
        bit       e_done;
        bit       e_busy;
        int       e_x;
        int       e_y;
    } vec_t;

    vec_t tv[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input bit r, input bit g, input int s);
        if (r) begin
            m_k = -1; m_scr = 0; m_x = 0; m_y = 0;
        end else if (m_k == -1 || m_k == N + 1) begin
            if (g) begin
                m_k = 0; m_scr = s;
            end else begin
                m_k = -1;
            end
        end else begin
            m_k++;
        end
        if (m_k >= 1 && m_k <= N) begin
            m_x = (m_k - 1) % W;
            m_y = (m_k - 1) / W;
        end
    endfunction

    task automatic step(input bit r, input bit g, input int s);
        reset = r; go = g; screen_sel = 2'(s);
        @(posedge clk);
        #1;
        model_edge(r, g, s);
    endtask

    task automatic check_model();
        bit e_plot;
        e_plot = (m_k >= 1 && m_k <= N);
        chk("plot", 32'(plot), 32'(e_plot));
        chk("plot_done", 32'(plot_done), 32'(m_k == N + 1));
        chk("busy", 32'(busy), 32'(m_k >= 0 && m_k <= N));
        chk("x", 32'(x), 32'(m_x));
        chk("y", 32'(y), 32'(m_y));
        chk("rom_scr", 32'(rom_scr), 32'(m_scr));
        if (e_plot) chk("colour", 32'(colour), 32'((m_k - 1) % 8));
        if (m_k >= 0 && m_k < N) chk("rom_addr", 32'(rom_addr), 32'(m_k));
    endtask

    initial begin
        int plots, dones;

        tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[2]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 2, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 3, 0, 0, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 0, 0, 0, 0, 0};
        tv[6]  = '{1, 1, 1, 0, 0, 0, 0, 0};
        tv[7]  = '{0, 0, 1, 0, 0, 0, 0, 0};
        tv[8]  = '{0, 1, 2, 0, 0, 1, 0, 0};
        tv[9]  = '{0, 0, 0, 1, 0, 1, 0, 0};
        tv[10] = '{0, 0, 0, 1, 0, 1, 1, 0};
        tv[11] = '{0, 1, 0, 1, 0, 1, 2, 0};

        // Reset, idle, reset+go together, then the start of a screen-2 frame
        // with a stray go (screen 0) arriving mid-draw.
        for (int i = 0; i < 12; i++) begin
            step(tv[i].rst, tv[i].go, tv[i].sel);
            chk("vec_plot", 32'(plot), 32'(tv[i].e_plot));
            chk("vec_done", 32'(plot_done), 32'(tv[i].e_done));
            chk("vec_busy", 32'(busy), 32'(tv[i].e_busy));
            chk("vec_x", 32'(x), 32'(tv[i].e_x));
            chk("vec_y", 32'(y), 32'(tv[i].e_y));
            if (tv[i].e_plot) chk("vec_colour", 32'(colour), 32'(tv[i].e_x));
            if (tv[i].rst) chk("vec_rom_addr_rst", 32'(rom_addr), 32'd0);
        end
        chk("rom_scr_latched", 32'(rom_scr), 32'd2);

        // Rest of that frame: 3 plots seen so far, 9 more, then one done.
        plots = 3; dones = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0);
            check_model();
            plots += int'(plot);
            dones += int'(plot_done);
        end
        chk("frame_plots", 32'(plots), 32'd12);
        chk("frame_dones", 32'(dones), 32'd1);
        chk("rom_scr_kept", 32'(rom_scr), 32'd2);

        // go held high for 40 cycles: 14-cycle frame period.
        plots = 0; dones = 0;
        for (int i = 0; i < 40; i++) begin
            step(0, 1, 3);
            check_model();
            plots += int'(plot);
            dones += int'(plot_done);
        end
        chk("held_go_dones", 32'(dones), 32'd2);
        chk("held_go_plots", 32'(plots), 32'd35);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1);
            check_model();
        end

        // Reset during the 6th plot cycle of a frame.
        step(0, 1, 1);
        check_model();
        plots = 0;
        for (int i = 0; i < 20 && plots < 6; i++) begin
            step(0, 0, 0);
            check_model();
            plots += int'(plot);
        end
        chk("plots_before_abort", 32'(plots), 32'd6);
        step(1, 0, 0);
        check_model();
        chk("abort_plot", 32'(plot), 32'd0);
        dones = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 0, 0);
            check_model();
            dones += int'(plot_done);
            chk("abort_no_plot", 32'(plot), 32'd0);
        end
        chk("abort_dones", 32'(dones), 32'd0);
        step(0, 1, 2);
        check_model();
        step(0, 0, 0);
        check_model();
        chk("restart_x", 32'(x), 32'd0);
        chk("restart_y", 32'(y), 32'd0);
        chk("restart_plot", 32'(plot), 32'd1);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 0);
            check_model();
        end

        // Random go / screen / occasional reset against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                 int'($urandom_range(0, 3)));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
